mc_solver_controller: RTL and testbench

- Run controller that sequences the missionaries/cannibals solver FSM on the board.
- Turns synchronized user controls (run/pause, single-step, clear) into solver reset, start and one-cycle step enables, and paces auto-run with a programmable tick.
- Watches the solver's reported state for completion and sequencing errors.
- Sits between the button/debounce block and the solver instance; also drives status LEDs.

---
 rtl/mc_solver_controller.sv | 185 ++++++++++++++++++
 tb/tb_mc_solver_controller.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mc_solver_controller.sv
// mc_solver_controller: run/pause/step/clear sequencer for the M/C solver; define MC_WATCHDOG_EN to add sequencing, validity and timeout fault checks
module mc_solver_controller #(
    parameter int TICK_DIV      = 5000000,
    parameter int HOLD_TICKS    = 4,
    parameter int TIMEOUT_STEPS = 13
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       run_btn,
    input  logic       step_btn,
    input  logic       clear_btn,
    input  logic       auto_restart,
    input  logic [1:0] speed_sel,
    input  logic [3:0] solver_state,
    input  logic       solver_complete,
    input  logic       solver_valid,
    output logic       solver_rst,
    output logic       solver_start,
    output logic       solver_step,
    output logic [2:0] ctrl_state,
    output logic       running,
    output logic       done,
    output logic       fault,
    output logic [3:0] step_count
);
    localparam int TW = $clog2(TICK_DIV + 1);
    localparam int HW = $clog2(HOLD_TICKS + 1);
    typedef enum logic [2:0] {IDLE = 3'd0, ARM = 3'd1, RUN = 3'd2, PAUSE = 3'd3, DONE = 3'd4, FAULT = 3'd5} state_t;
    state_t        state_q, state_d;
    logic [2:0]    run_sh_q, run_sh_d, step_sh_q, step_sh_d, clr_sh_q, clr_sh_d;
    logic          mode_q, mode_d, restart_q, restart_d;
    logic [TW-1:0] tick_q, tick_d, period_q, period_d, period_sel;
    logic [HW-1:0] hold_q, hold_d;
    logic [3:0]    cnt_q, cnt_d, cnt_inc;
    logic          run_e, step_e, clr_e, wrap, step, flt;

`ifdef MC_WATCHDOG_EN
    logic [3:0] exp_q, exp_d;
    logic       chk_q, chk_d;
    assign flt   = (state_q == RUN || state_q == PAUSE) &&
                   (!solver_valid || (chk_q && solver_state != exp_q) ||
                    (cnt_q >= 4'(TIMEOUT_STEPS) && !solver_complete));
    assign fault = state_q == FAULT;
    always_comb begin
        chk_d = step;
        exp_d = step ? ((state_q == ARM) ? 4'd1 : exp_q + 4'd1) : exp_q;
    end
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            exp_q <= '0;
            chk_q <= 1'b0;
        end else begin
            exp_q <= exp_d;
            chk_q <= chk_d;
        end
    end
`else
    logic unused;
    assign unused = ^{solver_state, solver_valid};
    assign flt    = 1'b0;
    assign fault  = 1'b0;
`endif

    always_comb begin
        run_sh_d   = {run_sh_q[1:0], run_btn};
        step_sh_d  = {step_sh_q[1:0], step_btn};
        clr_sh_d   = {clr_sh_q[1:0], clear_btn};
        run_e      = run_sh_q[1] & ~run_sh_q[2];
        step_e     = step_sh_q[1] & ~step_sh_q[2];
        clr_e      = clr_sh_q[1] & ~clr_sh_q[2];
        period_sel = TW'(TICK_DIV) >> speed_sel;
        wrap       = tick_q == period_q - TW'(1);
        cnt_inc    = (cnt_q == 4'd15) ? cnt_q : cnt_q + 4'd1;
        state_d    = state_q;
        mode_d     = mode_q;
        restart_d  = restart_q;
        tick_d     = tick_q;
        period_d   = period_q;
        hold_d     = hold_q;
        cnt_d      = cnt_q;
        step       = 1'b0;
        case (state_q)
            IDLE: begin
                cnt_d     = '0;
                restart_d = 1'b0;
                if (!clr_e && (run_e || step_e || restart_q)) begin
                    state_d = ARM;
                    mode_d  = run_e || !step_e;
                end
            end
            ARM: begin
                step     = 1'b1;
                cnt_d    = 4'd1;
                tick_d   = '0;
                period_d = period_sel;
                state_d  = clr_e ? IDLE : (mode_q ? RUN : PAUSE);
            end
            RUN: begin
                if (clr_e) begin
                    state_d = IDLE;
                end else if (flt) begin
                    state_d = FAULT;
                end else if (solver_complete) begin
                    state_d = DONE;
                    tick_d  = '0;
                    hold_d  = '0;
                end else if (run_e) begin
                    state_d = PAUSE;
                end else begin
                    step     = wrap;
                    tick_d   = wrap ? '0 : tick_q + TW'(1);
                    period_d = wrap ? period_sel : period_q;
                    cnt_d    = wrap ? cnt_inc : cnt_q;
                end
            end
            PAUSE: begin
                if (clr_e) begin
                    state_d = IDLE;
                end else if (flt) begin
                    state_d = FAULT;
                end else if (solver_complete) begin
                    state_d = DONE;
                    tick_d  = '0;
                    hold_d  = '0;
                end else if (run_e) begin
                    state_d  = RUN;
                    tick_d   = '0;
                    period_d = period_sel;
                end else begin
                    step  = step_e;
                    cnt_d = step_e ? cnt_inc : cnt_q;
                end
            end
            DONE: begin
                if (clr_e) begin
                    state_d = IDLE;
                end else begin
                    tick_d   = wrap ? '0 : tick_q + TW'(1);
                    period_d = wrap ? period_sel : period_q;
                    hold_d   = auto_restart ? hold_q + HW'(wrap) : '0;
                    if (auto_restart && wrap && hold_q == HW'(HOLD_TICKS - 1)) begin
                        state_d   = IDLE;
                        restart_d = 1'b1;
                    end
                end
            end
            FAULT: state_d = clr_e ? IDLE : FAULT;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            run_sh_q  <= '0;
            step_sh_q <= '0;
            clr_sh_q  <= '0;
            mode_q    <= 1'b0;
            restart_q <= 1'b0;
            tick_q    <= '0;
            period_q  <= TW'(TICK_DIV);
            hold_q    <= '0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            run_sh_q  <= run_sh_d;
            step_sh_q <= step_sh_d;
            clr_sh_q  <= clr_sh_d;
            mode_q    <= mode_d;
            restart_q <= restart_d;
            tick_q    <= tick_d;
            period_q  <= period_d;
            hold_q    <= hold_d;
            cnt_q     <= cnt_d;
        end
    end

    assign solver_rst   = state_q == IDLE;
    assign solver_start = state_q == ARM;
    assign solver_step  = step;
    assign ctrl_state   = state_q;
    assign running      = state_q == RUN;
    assign done         = state_q == DONE;
    assign step_count   = cnt_q;
endmodule

// File: tb/tb_mc_solver_controller.sv
// tb_mc_solver_controller: randomized scenarios against arithmetic pulse-time and state expectations, with a behavioural solver model
module tb_mc_solver_controller;
    localparam int TD = 16;
    localparam int HT = 4;
    localparam int TO = 13;
    logic       clk = 0;
    logic       reset_n = 1;
    logic       run_btn = 0, step_btn = 0, clear_btn = 0, auto_restart = 0;
    logic [1:0] speed_sel = 0;
    logic [3:0] sst = 0;
    logic       solver_complete, solver_valid;
    logic       solver_rst, solver_start, solver_step, running, done, fault;
    logic [2:0] ctrl_state;
    logic [3:0] step_count;
    int         goal = 12;
    bit         freeze5 = 0;
    bit         bad = 0;
    int         cyc = 0;
    int         checks = 0;
    int         errors = 0;
    int         got[$];
    int         expq[$];

    assign solver_complete = int'(sst) == goal;
    assign solver_valid    = !bad;

    mc_solver_controller #(.TICK_DIV(TD), .HOLD_TICKS(HT), .TIMEOUT_STEPS(TO)) dut (
        .clk(clk), .reset_n(reset_n), .run_btn(run_btn), .step_btn(step_btn), .clear_btn(clear_btn),
        .auto_restart(auto_restart), .speed_sel(speed_sel), .solver_state(sst),
        .solver_complete(solver_complete), .solver_valid(solver_valid), .solver_rst(solver_rst),
        .solver_start(solver_start), .solver_step(solver_step), .ctrl_state(ctrl_state),
        .running(running), .done(done), .fault(fault), .step_count(step_count)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) begin
        if (solver_rst) sst <= 4'd0;
        else if (solver_step && !(freeze5 && sst == 4'd5)) sst <= sst + 4'd1;
    end
    always @(negedge clk) if (solver_step) got.push_back(cyc);

    task automatic check(input string tag, input int obs, input int req);
        checks++;
        if (obs != req) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, req, cyc);
        end
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    task automatic press(input int which, output int at);
        at        = cyc;
        run_btn   = (which == 0 || which == 3);
        step_btn  = (which == 1 || which == 3);
        clear_btn = (which >= 2);
        repeat (2) @(negedge clk);
        run_btn   = 0;
        step_btn  = 0;
        clear_btn = 0;
    endtask

    task automatic cmp_pulses(input string tag);
        check({tag, "_npulse"}, got.size(), expq.size());
        for (int i = 0; i < got.size() && i < expq.size(); i++) check({tag, "_pulse"}, got[i], expq[i]);
        got.delete();
        expq.delete();
    endtask

    task automatic clear_to_idle(input string tag);
        int p;
        press(2, p);
        wait_until(p + 3);
        check({tag, "_clr_state"}, int'(ctrl_state), 0);
        check({tag, "_clr_rst"}, int'(solver_rst), 1);
        check({tag, "_clr_fault"}, int'(fault), 0);
        repeat (2) @(negedge clk);
        got.delete();
        expq.delete();
    endtask

    task automatic run_done(input int spd, input int g, input string tag, output int d);
        int p, a, per;
        speed_sel = 2'(spd);
        goal      = g;
        per       = TD >> spd;
        got.delete();
        expq.delete();
        press(0, p);
        a = p + 3;
        wait_until(a);
        check({tag, "_arm"}, int'(ctrl_state), 1);
        check({tag, "_start"}, int'(solver_start), 1);
        for (int j = 0; j < g; j++) expq.push_back(a + j * per);
        d = a + (g - 1) * per + 2;
        wait_until(d - 1);
        check({tag, "_running"}, int'(running), 1);
        wait_until(d);
        check({tag, "_done"}, int'(done), 1);
        check({tag, "_count"}, int'(step_count), g);
        wait_until(d + 1);
        cmp_pulses(tag);
    endtask

    initial begin
        int p, a, d, per, k, t, s, base, n;
        #2 reset_n = 0;
        repeat (3) @(negedge clk);
        check("rst_state", int'(ctrl_state), 0);
        check("rst_solver_rst", int'(solver_rst), 1);
        check("rst_start", int'(solver_start), 0);
        check("rst_step", int'(solver_step), 0);
        check("rst_flags", int'({running, done, fault}), 0);
        check("rst_count", int'(step_count), 0);
        reset_n = 1;
        repeat (2) @(negedge clk);
        check("idle_state", int'(ctrl_state), 0);

        run_done(0, 12, "plan", d);
        wait_until(d + 2 * TD);
        check("plan_hold", int'(ctrl_state), 4);
        check("plan_nomore", got.size(), 0);
        clear_to_idle("plan");

        for (int sp = 0; sp < 4; sp++) begin
            run_done(sp, int'($urandom_range(2, 12)), "auto", d);
            wait_until(d + 3 * (TD >> sp));
            check("auto_hold", int'(ctrl_state), 4);
            check("auto_nomore", got.size(), 0);
            clear_to_idle("auto");
        end

        for (int rep = 0; rep < 2; rep++) begin
            speed_sel = 2'($urandom_range(0, 2));
            per       = TD >> speed_sel;
            goal      = 12;
            k         = $urandom_range(1, 4);
            t         = (rep == 0) ? int'($urandom_range(1, 3)) : 3;
            press(0, p);
            a = p + 3;
            for (int j = 0; j <= k; j++) expq.push_back(a + j * per);
            wait_until(a + k * per);
            press(0, p);
            wait_until(p + 3);
            check("pause_state", int'(ctrl_state), 3);
            wait_until(p + 3 + 2 * per);
            for (int i = 0; i < t; i++) begin
                press(1, s);
                expq.push_back(s + 2);
                repeat (3) @(negedge clk);
            end
            check("pause_count", int'(step_count), k + 1 + t);
            if (rep == 0) begin
                press(0, p);
                base = p + per + 2;
                n    = goal - (k + 1 + t);
                for (int j = 0; j < n; j++) expq.push_back(base + j * per);
                d = base + (n - 1) * per + 2;
                wait_until(d);
                check("resume_done", int'(ctrl_state), 4);
                check("resume_count", int'(step_count), goal);
                wait_until(d + 2 * per);
                cmp_pulses("resume");
                clear_to_idle("resume");
            end else begin
                press(3, p);
                wait_until(p + 3);
                check("triple_idle", int'(ctrl_state), 0);
                wait_until(p + 6);
                cmp_pulses("triple");
            end
        end

        auto_restart = 1;
        per = TD >> 1;
        run_done(1, int'($urandom_range(2, 5)), "ar", d);
        wait_until(d + HT * per - 1);
        check("ar_hold", int'(ctrl_state), 4);
        @(negedge clk);
        check("ar_idle", int'(ctrl_state), 0);
        check("ar_rst", int'(solver_rst), 1);
        @(negedge clk);
        check("ar_arm", int'(ctrl_state), 1);
        @(negedge clk);
        check("ar_run", int'(ctrl_state), 2);
        check("ar_count", int'(step_count), 1);
        a = d + HT * per + 1;
        d = a + (goal - 1) * per + 2;
        wait_until(d + 2 * per);
        check("ar_done2", int'(ctrl_state), 4);
        auto_restart = 0;
        wait_until(d + 6 * per);
        check("ar_cancel", int'(ctrl_state), 4);
        clear_to_idle("ar");

        speed_sel = 2;
        per       = 4;
        goal      = 15;
        freeze5   = 1;
        press(0, p);
        a = p + 3;
        wait_until(a + 5 * per + 1);
        check("seq_pre", int'(running), 1);
`ifdef MC_WATCHDOG_EN
        @(negedge clk);
        check("seq_fault", int'(fault), 1);
        check("seq_state", int'(ctrl_state), 5);
        got.delete();
        press(1, s);
        repeat (4) @(negedge clk);
        check("seq_nostep", got.size(), 0);
        check("seq_sticky", int'(fault), 1);
`else
        repeat (3) @(negedge clk);
        check("seq_still_run", int'(running), 1);
        check("seq_nofault", int'(fault), 0);
`endif
        freeze5 = 0;
        clear_to_idle("seq");

        speed_sel = 3;
        goal      = 20;
        press(0, p);
        a = p + 3;
`ifdef MC_WATCHDOG_EN
        wait_until(a + 25);
        check("to_run", int'(ctrl_state), 2);
        check("to_count", int'(step_count), 13);
        @(negedge clk);
        check("to_fault", int'(ctrl_state), 5);
`else
        wait_until(a + 27);
        check("sat_14", int'(step_count), 14);
        wait_until(a + 33);
        check("sat_15", int'(step_count), 15);
        wait_until(a + 41);
        check("sat_hold", int'(step_count), 15);
`endif
        clear_to_idle("to");

        speed_sel = 1;
        goal      = 12;
        press(0, p);
        wait_until(p + 8);
        bad = 1;
        @(negedge clk);
`ifdef MC_WATCHDOG_EN
        check("valid_fault", int'(ctrl_state), 5);
`else
        check("valid_ignored", int'(ctrl_state), 2);
`endif
        bad = 0;
        clear_to_idle("valid");

        speed_sel = 0;
        press(0, p);
        wait_until(p + 10);
        check("mid_running", int'(running), 1);
        reset_n = 0;
        #1;
        check("async_state", int'(ctrl_state), 0);
        check("async_rst", int'(solver_rst), 1);
        check("async_flags", int'({running, done, fault, solver_step, solver_start}), 0);
        check("async_count", int'(step_count), 0);
        @(negedge clk);
        reset_n = 1;
        repeat (2) @(negedge clk);
        check("post_rst_state", int'(ctrl_state), 0);
        check("post_rst_rst", int'(solver_rst), 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
